dct_transpose_ctrl: RTL and testbench
=====================================

Name: dct_transpose_ctrl

Overview:
- Ping-pong transpose-buffer controller between the row-pass and column-pass PE arrays of the 2-D DCT.
- Accepts row-pass results in row-major order and writes them into one of two N×N banks of a shared dual-port RAM.
- Once a bank is full, it reads that bank back in transposed (column-major) order and streams it to the column pass, with backpressure.
- The RAM itself is external; this block only sequences it.

Parameters:
DATA_WIDTH, 10, coefficient/sample width
N, 8, block dimension; one block = N*N words; N must be a power of 2
AW, $clog2(2*N*N), RAM address width (derived, not overridable)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_data  input  DATA_WIDTH  row-pass result word
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
wr_addr  output  AW  RAM write address {bank, row*N+col}
wr_en  output  1  RAM write strobe
wr_data  output  DATA_WIDTH  RAM write data
rd_addr  output  AW  RAM read address
rd_en  output  1  RAM read strobe
rd_data  input  DATA_WIDTH  RAM read data, valid exactly 1 cycle after rd_en
out_data  output  DATA_WIDTH  transposed word to the column pass
out_load  output  1  out_data valid
out_ready  input  1  column pass accepts out_data
out_last  output  1  qualifies out_load on the final word (N*N-th) of a block
bank_full  output  2  per-bank full flags (status)

Behaviour:
- One clock (clk). rst_n is asynchronous, active-low.
- Reset values:
  - in_ready=1.
  - wr_en, rd_en, out_load, out_last = 0.
  - All addresses, out_data and bank_full = 0.
  - wbank=0, rbank=0, write and read counters = 0, read FSM = IDLE, output FIFO empty.
- Write side:
  - A word is accepted when in_valid && in_ready.
  - in_ready = !bank_full[wbank], combinational from flops.
  - On accept, the write is combinational in the same cycle: wr_en=1, wr_data=in_data, wr_addr={wbank,wcnt}.
  - wcnt increments on each accept.
  - On accepting wcnt==N*N-1: set bank_full[wbank], toggle wbank, clear wcnt (all at that edge).
- Read FSM states: IDLE, READ, DRAIN.
  - IDLE: if bank_full[rbank], go to READ at the next edge; rcnt=0.
  - READ:
    - Read k=rcnt maps to row=k%N, col=k/N; rd_addr={rbank,row*N+col}.
    - Credit rule: rd_en=1 only when fifo_count + reads_in_flight < 2, where fifo_count is taken after this cycle's pop.
    - rcnt increments on each rd_en.
    - After issuing read N*N-1, go to DRAIN.
  - DRAIN:
    - Wait until the word with out_last has been popped (out_load && out_ready && out_last).
    - Then clear bank_full[rbank], toggle rbank, and return to IDLE at that edge.
- Output:
  - 2-entry FIFO; rd_data is written to it the cycle it arrives. out_load = FIFO non-empty; out_data = FIFO head.
  - out_last is carried with the word that was read for k==N*N-1.
  - While out_load && !out_ready, out_data, out_load and out_last hold stable.
  - With out_ready held high, output runs at 1 word/cycle with no bubbles within a block.
- Latency:
  - Last write accepted at cycle t: IDLE at t+1, first rd_en at t+2, rd_data at t+3, first out_load at t+4.
  - Block-to-block restart adds the DRAIN→IDLE→READ cycles (a bubble of at least 2 cycles between blocks is acceptable).
- Boundaries:
  - Both banks full: in_ready=0 until the read side releases a bank; in_ready rises the cycle after release.
  - Release and fill in the same cycle always target different banks; each flag must update independently.
  - A bank is never written while it is full, and never read while it is not full.
  - in_valid low mid-block pauses wcnt with no timeout.
  - Counters wrap only through the end-of-block rules above.
- Reset mid-operation:
  - Immediately returns to the reset state; all buffered data is discarded.
  - The next accepted word is element 0 of bank 0.
- Widths: wcnt and rcnt are $clog2(N*N) bits; row and col are bit-slices of the counter (power-of-2 N); no arithmetic beyond this.

Test Plan:
1. Single block, in_data=k for k=0..63, out_ready=1 → output sequence 0,8,16,…,56,1,9,…,63; out_last only on 63; first out_load 4 cycles after the last accept; 64 consecutive out_load cycles.
2. Three back-to-back blocks, in_valid held 1, out_ready=1 → all 192 words emerge in transposed order per block and block order is preserved; in_ready may drop briefly; no word lost or duplicated.
3. out_ready random 50% during a block → out_data/out_last stable while stalled; never more than 2 reads outstanding plus buffered; exact 64-word transposed sequence.
4. out_ready=0, feed 128 words → bank_full=2'b11 and in_ready=0 after word 127. Raise out_ready → in_ready returns the cycle after bank 0's out_last pop; bank_full=2'b10.
5. Assert rst_n=0 asynchronously after 20 words have been output → all outputs at reset values without waiting for a clock edge. New block 100..163 → output starts at 100,108,…, with no residue from the old block.
6. Time block 2's last write to the same cycle as bank 0's release → bank_full goes 2'b01→2'b10 in one edge; the read FSM starts on bank 1 next.

Source files
------------

// File: rtl/dct_transpose_ctrl.sv
// Ping-pong transpose buffer sequencer: row-major writes into one bank of an external
// dual-port RAM, column-major read-back streamed out through a 2-entry skid FIFO.
module dct_transpose_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int N = 8,
  localparam int AW = $clog2(2 * N * N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [AW-1:0]         wr_addr,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [AW-1:0]         rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_load,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [1:0]            bank_full
);
  localparam int CW = $clog2(N * N);
  localparam int LW = $clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N * N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                     state_r, state_next_s;
  logic                       wbank_r, rbank_r;
  logic [CW-1:0]              wcnt_r, rcnt_r;
  logic [1:0]                 bank_full_r, set_s, clr_s;
  logic                       rd_pend_r, rd_pend_last_r;
  logic [1:0][DATA_WIDTH-1:0] fifo_data_r;
  logic [1:0]                 fifo_last_r;
  logic                       fifo_wptr_r, fifo_rptr_r;
  logic [1:0]                 fifo_count_r;
  logic                       accept_s, fill_done_s, pop_s, release_s, credit_ok_s;
  logic [2:0]                 occupancy_s;

  assign in_ready    = ~bank_full_r[wbank_r];
  assign accept_s    = in_valid & in_ready;
  assign fill_done_s = accept_s & (wcnt_r == CNT_MAX);
  assign wr_en       = accept_s;
  assign wr_data     = in_data;
  assign wr_addr     = {wbank_r, wcnt_r};

  assign out_load = (fifo_count_r != 2'd0);
  assign out_data = fifo_data_r[fifo_rptr_r];
  assign out_last = out_load & fifo_last_r[fifo_rptr_r];
  assign pop_s    = out_load & out_ready;

  // Words already committed to the FIFO after this cycle's pop; never let it exceed two.
  assign occupancy_s = {1'b0, fifo_count_r} + {2'b00, rd_pend_r} - {2'b00, pop_s};
  assign credit_ok_s = (occupancy_s < 3'd2);
  assign rd_en       = (state_r == READ) & credit_ok_s;
  // Read index k walks column-major: row = k % N (low bits), col = k / N (high bits).
  assign rd_addr     = {rbank_r, rcnt_r[LW-1:0], rcnt_r[CW-1:LW]};
  assign release_s   = (state_r == DRAIN) & pop_s & out_last;

  assign set_s     = fill_done_s ? (wbank_r ? 2'b10 : 2'b01) : 2'b00;
  assign clr_s     = release_s ? (rbank_r ? 2'b10 : 2'b01) : 2'b00;
  assign bank_full = bank_full_r;

  // Read sequencer next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bank_full_r[rbank_r]) state_next_s = READ;
        else                      state_next_s = IDLE;
      end
      READ: begin
        if (rd_en && (rcnt_r == CNT_MAX)) state_next_s = DRAIN;
        else                              state_next_s = READ;
      end
      DRAIN: begin
        if (release_s) state_next_s = IDLE;
        else           state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Bank bookkeeping, counters and the read sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      wbank_r        <= 1'b0;
      rbank_r        <= 1'b0;
      wcnt_r         <= '0;
      rcnt_r         <= '0;
      bank_full_r    <= 2'b00;
      rd_pend_r      <= 1'b0;
      rd_pend_last_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      bank_full_r    <= (bank_full_r | set_s) & ~clr_s;
      rd_pend_r      <= rd_en;
      rd_pend_last_r <= rd_en & (rcnt_r == CNT_MAX);
      if (fill_done_s) begin
        wcnt_r  <= '0;
        wbank_r <= ~wbank_r;
      end else if (accept_s) begin
        wcnt_r <= wcnt_r + CW'(1);
      end
      if (release_s) rbank_r <= ~rbank_r;
      if (state_r == IDLE) rcnt_r <= '0;
      else if (rd_en)      rcnt_r <= rcnt_r + CW'(1);
    end
  end

  // Output FIFO: captures rd_data the cycle it returns, head drives the column pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_r  <= '0;
      fifo_last_r  <= 2'b00;
      fifo_wptr_r  <= 1'b0;
      fifo_rptr_r  <= 1'b0;
      fifo_count_r <= 2'd0;
    end else begin
      if (rd_pend_r) begin
        fifo_data_r[fifo_wptr_r] <= rd_data;
        fifo_last_r[fifo_wptr_r] <= rd_pend_last_r;
        fifo_wptr_r              <= ~fifo_wptr_r;
      end
      if (pop_s) fifo_rptr_r <= ~fifo_rptr_r;
      fifo_count_r <= fifo_count_r + {1'b0, rd_pend_r} - {1'b0, pop_s};
    end
  end
endmodule

// File: tb/tb_dct_transpose_ctrl.sv
// Directed bench for dct_transpose_ctrl with a behavioural dual-port RAM.
module tb_dct_transpose_ctrl;
  localparam int DW = 10;
  localparam int N  = 8;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data, wr_data, rd_data, out_data;
  logic          in_valid, in_ready, wr_en, rd_en, out_load, out_ready, out_last;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [1:0]    bank_full;
  logic [DW-1:0] mem [0:127];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int total_acc = 0;
  int last_acc_cyc, first_load_cyc, last_pop_cyc;

  dct_transpose_ctrl #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .out_data(out_data), .out_load(out_load), .out_ready(out_ready),
    .out_last(out_last), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External RAM: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; total_acc = 0;
  endtask

  task automatic feed(input int base, input int count);
    int i;
    int guard;
    i = 0; guard = 0;
    while (i < count && guard < 3000) begin
      @(negedge clk);
      guard++;
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      if (in_ready) begin
        #1;
        check_eq("wr_en", wr_en, 1);
        check_eq("wr_addr", wr_addr, total_acc % 128);
        check_eq("wr_data", wr_data, base + i);
        last_acc_cyc = cyc;
        total_acc++;
        i++;
      end
    end
    check_eq("feed_done", i, count);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Expected j-th output: block j/64 of inputs base+k, read back column-major.
  task automatic collect(input int base, input int count, input bit rnd);
    int j, guard, blk, k;
    bit stall, seen;
    logic [DW-1:0] hold_d;
    logic hold_l;
    j = 0; guard = 0; stall = 1'b0; seen = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (j < count && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (stall) begin
        check_eq("hold_load", out_load, 1);
        check_eq("hold_data", out_data, hold_d);
        check_eq("hold_last", out_last, hold_l);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_load && !seen) begin
        seen = 1'b1;
        first_load_cyc = cyc;
      end
      stall  = out_load && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (out_load && out_ready) begin
        blk = j / 64;
        k   = j % 64;
        check_eq("out_data", out_data, base + blk * 64 + (k % 8) * 8 + k / 8);
        check_eq("out_last", out_last, (k == 63) ? 1 : 0);
        last_pop_cyc = cyc;
        j++;
      end
    end
    check_eq("collect_done", j, count);
  endtask

  initial begin
    int g;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_load", out_load, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_rd_en", rd_en, 0);
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_bank_full", bank_full, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    rst_n = 1'b1;

    // Single block: latency and burst length.
    feed(0, 64);
    collect(0, 64, 1'b0);
    check_eq("t1_latency", first_load_cyc - last_acc_cyc, 4);
    check_eq("t1_burst", last_pop_cyc - first_load_cyc, 63);

    // Three back-to-back blocks.
    fork
      feed(300, 192);
      collect(300, 192, 1'b0);
    join

    // Random backpressure.
    fork
      feed(600, 64);
      collect(600, 64, 1'b1);
    join

    // Both banks full, then release of bank 0.
    do_reset();
    feed(700, 128);
    check_eq("t4_both_full", bank_full, 3);
    check_eq("t4_ready_low", in_ready, 0);
    repeat (5) @(negedge clk);
    check_eq("t4_ready_still_low", in_ready, 0);
    collect(700, 64, 1'b0);
    check_eq("t4_ready_before_release", in_ready, 0);
    @(negedge clk);
    check_eq("t4_ready_after_release", in_ready, 1);
    check_eq("t4_bank_full_10", bank_full, 2);
    collect(764, 64, 1'b0);

    // Asynchronous reset mid-block, then a fresh block.
    feed(900, 64);
    collect(900, 20, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_in_ready", in_ready, 1);
    check_eq("t5_out_load", out_load, 0);
    check_eq("t5_out_last", out_last, 0);
    check_eq("t5_out_data", out_data, 0);
    check_eq("t5_bank_full", bank_full, 0);
    check_eq("t5_rd_en", rd_en, 0);
    check_eq("t5_rd_addr", rd_addr, 0);
    check_eq("t5_wr_addr", wr_addr, 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; total_acc = 0;
    fork
      feed(100, 64);
      collect(100, 64, 1'b0);
    join

    // Bank 1 fill lands on the same edge as bank 0 release.
    do_reset();
    out_ready = 1'b1;
    fork
      collect(0, 128, 1'b0);
      begin
        feed(0, 127);
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!(out_load && out_last) && g < 500);
        check_eq("t6_sync", out_load && out_last, 1);
        check_eq("t6_bf_before", bank_full, 1);
        check_eq("t6_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = DW'(127);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("t6_bf_after", bank_full, 2);
        g = 0;
        while (!rd_en && g < 20) begin
          @(negedge clk);
          g++;
        end
        check_eq("t6_rd_en", rd_en, 1);
        check_eq("t6_rd_bank1", rd_addr, 64);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
